// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALUOp encodings, control bundle and FSM state type
// for the pipelined control unit.
package pipe_ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       jalrsel;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    IDLE,
    STALL
  } stall_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus source-register usage flags.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      R_TYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ARITH;
      end
      LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.aluop    = ALUOP_MEM;
      end
      SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALUOP_MEM;
      end
      BR: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_BR;
      end
      OP_IMM: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ARITH;
      end
      LUI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_PASS;
      end
      JAL: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.branch   = 1'b1;
        ctrl.aluop    = ALUOP_PASS;
      end
      JALR: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.jalrsel  = 1'b1;
        ctrl.aluop    = ALUOP_PASS;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign rs1_used = (opcode != LUI) && (opcode != JAL);
  assign rs2_used = (opcode == R_TYPE) || (opcode == SW) || (opcode == BR);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control register with load-use stall FSM and redirect flush; decode -> EX in one edge.
// Optional stall/flush performance counters under PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_opcode_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  ex_redirect_i,
  output logic                  ex_alusrc_o,
  output logic                  ex_memtoreg_o,
  output logic                  ex_regwrite_o,
  output logic                  ex_memread_o,
  output logic                  ex_memwrite_o,
  output logic [1:0]            ex_aluop_o,
  output logic                  ex_branch_o,
  output logic                  ex_jalrsel_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  illegal_o
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  localparam int CNT_BITS = $clog2(LOAD_LAT + 1);

  if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1) begin : g_bad_params
    $error("pipe_ctrl_unit: LOAD_LAT must be 1..7 and CNT_W positive");
  end

  ctrl_t                 id_ctrl;
  ctrl_t                 ex_ctrl;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  hazard;
  logic                  load_bubble;
  stall_state_t          state;
  stall_state_t          state_nxt;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_nxt;

  ctrl_decode u_decode (
    .opcode   (id_opcode_i),
    .ctrl     (id_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // x0 is hardwired, so a load targeting it never produces a dependency.
  assign hazard = ex_ctrl.memread && (ex_rd_o != '0) &&
                  ((rs1_used && (ex_rd_o == id_rs1_i)) ||
                   (rs2_used && (ex_rd_o == id_rs2_i)));

  assign flush_o = ex_redirect_i && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ex_redirect_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_BITS'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          cnt_nxt = cnt - CNT_BITS'(1);
          if (cnt == CNT_BITS'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A redirect squashes the ID instruction, so it overrides any pending stall.
  always_comb begin
    stall_o     = 1'b0;
    load_bubble = 1'b0;
    if (!reset) begin
      if (ex_redirect_i) begin
        load_bubble = 1'b1;
      end else begin
        case (state)
          IDLE:    stall_o = hazard;
          STALL:   stall_o = 1'b1;
          default: stall_o = 1'b0;
        endcase
        load_bubble = stall_o;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rd_o <= '0;
    end else if (load_bubble) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rd_o <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rd_o <= id_rd_i;
    end
  end

  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_memtoreg_o = ex_ctrl.memtoreg;
  assign ex_regwrite_o = ex_ctrl.regwrite;
  assign ex_memread_o  = ex_ctrl.memread;
  assign ex_memwrite_o = ex_ctrl.memwrite;
  assign ex_aluop_o    = ex_ctrl.aluop;
  assign ex_branch_o   = ex_ctrl.branch;
  assign ex_jalrsel_o  = ex_ctrl.jalrsel;
  assign illegal_o     = ex_ctrl.illegal;

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_o) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule
